afpm_host_driver: RTL

Host-side transmitter/receiver for the byte-serial FP16 approximate-multiplier port of the Tiny Tapeout tile. It accepts a pair of 16-bit FP16 operands over a valid/ready handshake, then sends them to the multiplier: a start token followed by two operand byte-pairs, low byte first. It then waits the multiplier's fixed latency, captures the two result bytes low-first, and presents the 16-bit product with a one-cycle valid. It sits on the FPGA/test-harness side and drives the tile's `ui_in`/`uio_in`/`uo_out`.

---
 rtl/afpm_host_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/afpm_host_driver.sv
// afpm_host_driver
//   Host-side byte-serial driver for the FP16 approximate-multiplier tile.
//   It accepts one operand pair over a valid/ready handshake and puts a start
//   token on the tile bus, then the low operand bytes, then the high operand
//   bytes. It waits out the tile's fixed latency, captures the two result
//   bytes low byte first, and presents the product with a one-cycle valid.
//
// Parameters
//   START_TOKEN : non-zero byte on tx_a that wakes the tile
//   CAP_LO      : low result byte is sampled at the edge ending cycle S+CAP_LO
//                 (S = start-token cycle); the high byte one edge later
//   FLUSH_CYC   : cycles req_ready stays low after reset release
//
// Ports
//   clk, rst           : clock shared with the tile; async active-high reset
//   req_valid/ready    : operand handshake; req_a/req_b are FP16 operands
//   res_valid/res_data : one-cycle result pulse; res_data holds until next capture
//   busy               : high from acceptance until res_valid
//   tx_a, tx_b         : drive tile ui_in / uio_in
//   rx_data            : from tile uo_out
//   All outputs are registered. There is no combinational path from any input.
module afpm_host_driver #(
  parameter logic [7:0] START_TOKEN = 8'h01,
  parameter int         CAP_LO      = 10,
  parameter int         FLUSH_CYC   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        busy,
  output logic [7:0]  tx_a,
  output logic [7:0]  tx_b,
  input  logic [7:0]  rx_data
);

  // A zero token would be indistinguishable from the idle bus.
  if (START_TOKEN == 8'h00) begin : g_tok_chk
    $error("afpm_host_driver: START_TOKEN must be non-zero");
  end
  // Token and operand cycles occupy S..S+2, so capture can be no earlier than S+3.
  if (CAP_LO < 3) begin : g_cap_chk
    $error("afpm_host_driver: CAP_LO must be >= 3");
  end
  if (FLUSH_CYC < 1) begin : g_flush_chk
    $error("afpm_host_driver: FLUSH_CYC must be >= 1");
  end

  // One down-counter serves both the flush guard and the latency wait.
  localparam int CMAX = (FLUSH_CYC > CAP_LO) ? FLUSH_CYC : CAP_LO;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_START, S_SEND_LO, S_SEND_HI, S_WAIT, S_CAP_LO, S_CAP_HI
  } state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } opnd_t;

  state_t        state;
  logic [CW-1:0] cnt;
  opnd_t         opq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // tx_a/tx_b clear asynchronously so the tile never sees a stray byte
      // while reset is held. The flush guard then lets an interrupted tile
      // transaction drain before a new token can go out.
      state     <= S_FLUSH;
      cnt       <= CW'(FLUSH_CYC - 1);
      opq       <= '0;
      req_ready <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
      busy      <= 1'b0;
      tx_a      <= 8'h00;
      tx_b      <= 8'h00;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_FLUSH: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // CAP_HI is the res_valid cycle. It already accepts a new pair,
        // which gives back-to-back throughput of one pair per 13 cycles.
        S_IDLE, S_CAP_HI: begin
          if (req_valid && req_ready) begin
            opq       <= '{a: req_a, b: req_b};
            busy      <= 1'b1;
            req_ready <= 1'b0;
            tx_a      <= START_TOKEN;
            tx_b      <= 8'h00;
            state     <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end

        S_START: begin
          tx_a  <= opq.a[7:0];
          tx_b  <= opq.b[7:0];
          state <= S_SEND_LO;
        end

        S_SEND_LO: begin
          tx_a  <= opq.a[15:8];
          tx_b  <= opq.b[15:8];
          state <= S_SEND_HI;
        end

        // The bus returns to zero. WAIT begins in cycle S+3, so a count of
        // CAP_LO-3 puts the low-byte capture on the edge ending S+CAP_LO.
        S_SEND_HI: begin
          tx_a  <= 8'h00;
          tx_b  <= 8'h00;
          cnt   <= CW'(CAP_LO - 3);
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (cnt == '0) begin
            res_data[7:0] <= rx_data;
            state         <= S_CAP_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_CAP_LO: begin
          res_data[15:8] <= rx_data;
          res_valid      <= 1'b1;
          busy           <= 1'b0;
          req_ready      <= 1'b1;
          state          <= S_CAP_HI;
        end

        default: begin
          state     <= S_FLUSH;
          cnt       <= CW'(FLUSH_CYC - 1);
          req_ready <= 1'b0;
          busy      <= 1'b0;
          tx_a      <= 8'h00;
          tx_b      <= 8'h00;
        end
      endcase
    end
  end

endmodule
